// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and helpers, used by the padder and the compression core.
package sha256_pkg;

    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned LEN_FIELD_W = 64;
    localparam int unsigned BLOCK_BYTES = BLOCK_W / 8;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } pad_state_e;

    // Padded length in blocks: message bits + 0x80 marker bit + 64-bit length field.
    function automatic int unsigned nblocks(input int unsigned len_bytes);
        return (len_bytes * 8 + LEN_FIELD_W + 1 + BLOCK_W - 1) / BLOCK_W;
    endfunction

endpackage

// File: rtl/sha256_pad_build.sv
// Combinational FIPS 180-4 pad builder: message bytes, 0x80, zeros, 64-bit bit length.
module sha256_pad_build
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BYTES  = 80,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned MAX_BLOCKS = 2,
    parameter int unsigned IDX_W      = 2
) (
    input  logic [MAX_BYTES*8-1:0]          i_data,
    input  logic [LEN_W-1:0]                i_len,
    output logic [MAX_BLOCKS*BLOCK_W-1:0]   o_buf,
    output logic [IDX_W-1:0]                o_nblk
);

    localparam int unsigned BUF_BYTES = MAX_BLOCKS * BLOCK_BYTES;
    localparam int unsigned BUF_W     = BUF_BYTES * 8;
    localparam int unsigned LEN_OFF   = BLOCK_BYTES - LEN_FIELD_W / 8;

    logic [BUF_W-1:0]       w_msg;
    logic [LEN_FIELD_W-1:0] w_len_bits;
    int unsigned            w_len_int;
    int unsigned            w_nblk_int;

    // Message widened to the buffer so every byte position has a source.
    assign w_msg      = {i_data, {(BUF_W - MAX_BYTES * 8){1'b0}}};
    assign w_len_bits = LEN_FIELD_W'(i_len) << 3;
    assign w_len_int  = 32'(i_len);
    assign w_nblk_int = nblocks(w_len_int);
    assign o_nblk     = IDX_W'(w_nblk_int);

    // Byte-wise mux keyed on the length; the length field lands in the last block only.
    always_comb begin
        o_buf = '0;
        for (int unsigned b = 0; b < BUF_BYTES; b++) begin
            if (b < w_len_int) begin
                o_buf[BUF_W-1-8*b -: 8] = w_msg[BUF_W-1-8*b -: 8];
            end else if (b == w_len_int) begin
                o_buf[BUF_W-1-8*b -: 8] = 8'h80;
            end
            if ((b / BLOCK_BYTES == w_nblk_int - 1) && (b % BLOCK_BYTES >= LEN_OFF)) begin
                o_buf[BUF_W-1-8*b -: 8] =
                    w_len_bits[LEN_FIELD_W-1-8*((b % BLOCK_BYTES) - LEN_OFF) -: 8];
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: accepts one message, streams its padded 512-bit blocks.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 80,
    parameter int unsigned LEN_W     = 16,
    localparam int unsigned MAX_BLOCKS = nblocks(MAX_BYTES),
    localparam int unsigned IDX_W      = $clog2(MAX_BLOCKS) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [MAX_BYTES*8-1:0] i_in_data,
    input  logic [LEN_W-1:0]       i_in_len,
    output logic                   o_len_err,
    output logic                   o_blk_valid,
    input  logic                   i_blk_ready,
    output logic [BLOCK_W-1:0]     o_blk_data,
    output logic                   o_blk_first,
    output logic                   o_blk_last,
    output logic [IDX_W-1:0]       o_blk_idx
);

    localparam int unsigned BUF_W = MAX_BLOCKS * BLOCK_W;

    pad_state_e         r_state, w_state_nxt;
    logic               r_rdy_en;
    logic [BUF_W-1:0]   r_buf, w_buf_nxt, w_pad_buf;
    logic [IDX_W-1:0]   r_nblk, w_nblk_nxt, w_pad_nblk;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_len_err, w_len_err_nxt;
    logic               w_accept, w_len_ok, w_last;
    logic [BLOCK_W-1:0] w_blk;

    sha256_pad_build #(
        .MAX_BYTES  (MAX_BYTES),
        .LEN_W      (LEN_W),
        .MAX_BLOCKS (MAX_BLOCKS),
        .IDX_W      (IDX_W)
    ) u_build (
        .i_data (i_in_data),
        .i_len  (i_in_len),
        .o_buf  (w_pad_buf),
        .o_nblk (w_pad_nblk)
    );

    assign w_accept = i_in_valid & o_in_ready;
    assign w_len_ok = (i_in_len <= LEN_W'(MAX_BYTES));
    assign w_last   = (r_idx == r_nblk - IDX_W'(1));

    // State and datapath registers; reset aborts any message in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_rdy_en  <= 1'b0;
            r_buf     <= '0;
            r_nblk    <= '0;
            r_idx     <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rdy_en  <= 1'b1;
            r_buf     <= w_buf_nxt;
            r_nblk    <= w_nblk_nxt;
            r_idx     <= w_idx_nxt;
            r_len_err <= w_len_err_nxt;
        end
    end

    // Next-state: capture the padded buffer on acceptance, step blocks on each handshake.
    always_comb begin
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_nblk_nxt    = r_nblk;
        w_idx_nxt     = r_idx;
        w_len_err_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_len_ok) begin
                        w_state_nxt = StEmit;
                        w_buf_nxt   = w_pad_buf;
                        w_nblk_nxt  = w_pad_nblk;
                        w_idx_nxt   = '0;
                    end else begin
                        w_len_err_nxt = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (i_blk_ready) begin
                    if (w_last) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Select the current block out of the registered buffer.
    always_comb begin
        w_blk = '0;
        for (int unsigned k = 0; k < MAX_BLOCKS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_blk = r_buf[BUF_W-1-BLOCK_W*k -: BLOCK_W];
            end
        end
    end

    // Block outputs are forced to zero whenever no block is being offered.
    assign o_in_ready  = r_rdy_en & (r_state == StIdle);
    assign o_blk_valid = (r_state == StEmit);
    assign o_blk_data  = o_blk_valid ? w_blk : '0;
    assign o_blk_first = o_blk_valid & (r_idx == '0);
    assign o_blk_last  = o_blk_valid & w_last;
    assign o_blk_idx   = o_blk_valid ? r_idx : '0;
    assign o_len_err   = r_len_err;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder with hand-computed padded blocks.
module tb_sha256_msg_padder;

    localparam int MB = 80;
    localparam int LW = 16;
    localparam int IW = 2;
    localparam int DW = MB * 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [LW-1:0] in_len;
    logic          len_err;
    logic          blk_valid;
    logic          blk_ready;
    logic [511:0]  blk_data;
    logic          blk_first;
    logic          blk_last;
    logic [IW-1:0] blk_idx;

    int n_checks = 0;
    int n_fail   = 0;

    sha256_msg_padder #(
        .MAX_BYTES (MB),
        .LEN_W     (LW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_data   (in_data),
        .i_in_len    (in_len),
        .o_len_err   (len_err),
        .o_blk_valid (blk_valid),
        .i_blk_ready (blk_ready),
        .o_blk_data  (blk_data),
        .o_blk_first (blk_first),
        .o_blk_last  (blk_last),
        .o_blk_idx   (blk_idx)
    );

    always #5 clk = ~clk;

    // Hand-computed padded blocks.
    localparam logic [511:0] K_SEQ0 = {128'h000102030405060708090a0b0c0d0e0f,
                                       128'h101112131415161718191a1b1c1d1e1f,
                                       128'h202122232425262728292a2b2c2d2e2f,
                                       128'h303132333435363738393a3b3c3d3e3f};
    localparam logic [511:0] K80_B1 = {128'h404142434445464748494a4b4c4d4e4f,
                                       128'h80000000000000000000000000000000,
                                       128'h0, 128'h280};
    localparam logic [511:0] K_ABC  = {128'h61626380000000000000000000000000,
                                       128'h0, 128'h0, 128'h18};
    localparam logic [511:0] K55    = {128'h000102030405060708090a0b0c0d0e0f,
                                       128'h101112131415161718191a1b1c1d1e1f,
                                       128'h202122232425262728292a2b2c2d2e2f,
                                       128'h303132333435368000000000000001b8};
    localparam logic [511:0] K56_B0 = {128'h000102030405060708090a0b0c0d0e0f,
                                       128'h101112131415161718191a1b1c1d1e1f,
                                       128'h202122232425262728292a2b2c2d2e2f,
                                       128'h30313233343536378000000000000000};
    localparam logic [511:0] K56_B1 = {128'h0, 128'h0, 128'h0, 128'h1c0};
    localparam logic [511:0] K0     = {128'h80000000000000000000000000000000,
                                       128'h0, 128'h0, 128'h0};

    typedef struct {
        string        name;
        int           pat;   // 0: bytes 0,1,2..  1: "abc.."
        int           len;
        int           nblk;
        logic [511:0] b0;
        logic [511:0] b1;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Bytes past the length are filled with 0xFF so leakage shows up.
    function automatic logic [DW-1:0] mk_data(input int pat, input int len);
        logic [DW-1:0] d;
        d = '1;
        for (int b = 0; b < len && b < MB; b++) begin
            d[DW-1-8*b -: 8] = (pat == 1) ? 8'(8'h61 + b) : 8'(b);
        end
        return d;
    endfunction

    // Full message with blk_ready held high; entered and left on a negedge.
    task automatic run_msg(input vec_t v);
        chk($sformatf("%s in_ready pre", v.name), 512'(in_ready), 512'(1));
        in_valid  = 1'b1;
        in_data   = mk_data(v.pat, v.len);
        in_len    = LW'(v.len);
        blk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        for (int k = 0; k < v.nblk; k++) begin
            chk($sformatf("%s b%0d valid", v.name, k), 512'(blk_valid), 512'(1));
            chk($sformatf("%s b%0d in_ready", v.name, k), 512'(in_ready), 512'(0));
            chk($sformatf("%s b%0d data", v.name, k), blk_data, (k == 0) ? v.b0 : v.b1);
            chk($sformatf("%s b%0d first", v.name, k), 512'(blk_first), 512'(k == 0));
            chk($sformatf("%s b%0d last", v.name, k), 512'(blk_last), 512'(k == v.nblk - 1));
            chk($sformatf("%s b%0d idx", v.name, k), 512'(blk_idx), 512'(k));
            chk($sformatf("%s b%0d len_err", v.name, k), 512'(len_err), 512'(0));
            @(negedge clk);
        end
        chk($sformatf("%s done valid", v.name), 512'(blk_valid), 512'(0));
        chk($sformatf("%s done in_ready", v.name), 512'(in_ready), 512'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"len80", 0, 80, 2, K_SEQ0, K80_B1};
        vecs[1] = '{"abc",   1, 3,  1, K_ABC,  '0};
        vecs[2] = '{"len55", 0, 55, 1, K55,    '0};
        vecs[3] = '{"len56", 0, 56, 2, K56_B0, K56_B1};
        vecs[4] = '{"len0",  0, 0,  1, K0,     '0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        blk_ready = 1'b0;

        // Reset state
        #12;
        chk("rst in_ready", 512'(in_ready), 512'(0));
        chk("rst blk_valid", 512'(blk_valid), 512'(0));
        chk("rst blk_data", blk_data, '0);
        chk("rst flags", 512'({blk_first, blk_last, len_err, blk_idx}), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", 512'(in_ready), 512'(1));

        // Table-driven messages
        foreach (vecs[i]) begin
            run_msg(vecs[i]);
        end

        // Backpressure on block 0 for five cycles
        blk_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk_data(0, 80);
        in_len    = LW'(80);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp c%0d valid", c), 512'(blk_valid), 512'(1));
            chk($sformatf("bp c%0d data", c), blk_data, K_SEQ0);
            chk($sformatf("bp c%0d first", c), 512'(blk_first), 512'(1));
            chk($sformatf("bp c%0d idx", c), 512'(blk_idx), 512'(0));
            chk($sformatf("bp c%0d in_ready", c), 512'(in_ready), 512'(0));
            if (c == 4) blk_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp b1 data", blk_data, K80_B1);
        chk("bp b1 last", 512'(blk_last), 512'(1));
        chk("bp b1 idx", 512'(blk_idx), 512'(1));
        @(negedge clk);
        chk("bp done valid", 512'(blk_valid), 512'(0));
        chk("bp done in_ready", 512'(in_ready), 512'(1));

        // Over-length message
        in_valid = 1'b1;
        in_data  = mk_data(0, 80);
        in_len   = LW'(81);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lenerr pulse", 512'(len_err), 512'(1));
        chk("lenerr valid", 512'(blk_valid), 512'(0));
        chk("lenerr in_ready", 512'(in_ready), 512'(1));
        @(negedge clk);
        chk("lenerr pulse end", 512'(len_err), 512'(0));
        chk("lenerr valid2", 512'(blk_valid), 512'(0));

        // Reset during block 0
        blk_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk_data(0, 80);
        in_len    = LW'(80);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst valid before", 512'(blk_valid), 512'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst valid async", 512'(blk_valid), 512'(0));
        chk("midrst in_ready", 512'(in_ready), 512'(0));
        chk("midrst data", blk_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst recover valid", 512'(blk_valid), 512'(0));
        run_msg(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
